disp_arbiter: RTL
=================

DISP_ARBITER -- requirements
Module: disp_arbiter

Interface
REQ-001 SHALL have parameter DWELL, default 10**8 (1 s at 100 MHz), minimum grant time in CLK cycles, legal range 2..2**32-1.
REQ-002 SHALL have port CLK, input, 1, single system clock, all state on rising edge.
REQ-003 SHALL have port RST_N, input, 1, reset, asynchronous, active-low.
REQ-004 SHALL have port req, input, 4, request per requester i, level, held while requester wants the display.
REQ-005 SHALL have port x_in, input, 64, requester i value at bits [16i+15:16i].
REQ-006 SHALL have port neg_in, input, 16, requester i per-digit negative flags at bits [4i+3:4i].
REQ-007 SHALL have port gnt, output, 4, one-hot grant, registered, all-zero when idle.
REQ-008 SHALL have port owner, output, 2, index of granted requester, registered.
REQ-009 SHALL have port valid, output, 1, high while a grant is active.
REQ-010 SHALL have port x, output, 16, value to the 4-digit hex display driver, registered.
REQ-011 SHALL have port neg, output, 4, per-digit negative flags to the display driver, registered.

Function
REQ-012 SHALL implement FSM states IDLE and GRANT, plus a 32-bit dwell counter cnt and a 2-bit round-robin pointer last.
REQ-013 Pick SHALL be the first i with req[i]=1, searching last+1, last+2, ... modulo 4.
REQ-014 In IDLE with any req high, the next edge SHALL set state=GRANT, gnt=onehot(pick), owner=pick, last=pick, cnt=0, valid=1.
REQ-015 Grant latency SHALL be exactly 1 cycle from req rising to gnt asserted.
REQ-016 In GRANT, each edge SHALL register x=x_in[owner] and neg=neg_in[owner], so data lags x_in by 1 cycle.
REQ-017 In GRANT, cnt SHALL increment per cycle, saturating at DWELL-1.
REQ-018 Before cnt reaches DWELL-1, the grant SHALL be held even if req[owner] drops (minimum dwell).
REQ-019 At cnt==DWELL-1 with any other req[j] high (j != owner), the next edge SHALL switch directly to the pick, cnt=0, with no idle cycle between grants.
REQ-020 At cnt==DWELL-1 with no other request and req[owner]=1, the grant SHALL be held indefinitely.
REQ-021 At cnt==DWELL-1 with no other request and req[owner]=0, the next edge SHALL enter IDLE with gnt=0, valid=0, x=0, neg=0.
REQ-022 If req[owner] drops on the same cycle that cnt==DWELL-1 and others are pending, the block SHALL switch per REQ-019.
REQ-023 In IDLE, x, neg, gnt and valid SHALL be 0.

Reset
REQ-024 RST_N low SHALL asynchronously force state=IDLE, gnt=0, owner=0, valid=0, x=0, neg=0, cnt=0, last=3, so requester 0 wins the first arbitration.
REQ-025 Reset asserted mid-grant SHALL abort the grant immediately, with no completion of the dwell.

Configuration
REQ-026 Macro DISP_ARBITER_PRIO_EN defined: req[0] SHALL always win the pick, and owner 0 SHALL retain the grant while req[0]=1 after the minimum dwell, even if others are pending; minimum dwell still applies before any preemption by 0.
REQ-027 Macro undefined: pure round-robin per REQ-013 and REQ-019.

Structure
REQ-028 Shared package disp_pkg SHALL hold the state enum (IDLE, GRANT), N_REQ=4, DIGIT_W=4 and DISP_W=16.
REQ-029 Round-robin selection SHALL be one combinational sub-module, rr_pick (inputs req and last; outputs pick and any), with the priority option applied inside it.

Verification (DWELL=4)
REQ-030 Reset, then req=0001 -> gnt=0001 one cycle later; x tracks x_in[15:0] (e.g. 16'h1234) with 1-cycle lag; valid=1.
REQ-031 req=1111 held -> owner sequence 0,1,2,3,0, each owner exactly 4 cycles, gnt one-hot throughout.
REQ-032 req[0] pulse of 1 cycle -> gnt=0001 for 4 cycles, then IDLE with x=0, neg=0.
REQ-033 Owner 2 alone for 20 cycles, then req[1] rises -> switch to 1 on the next edge after cnt==3 (already saturated), with no idle cycle.
REQ-034 RST_N low mid-grant -> gnt, valid, x and neg are 0 asynchronously; after release, req=1010 -> owner=1 first.
REQ-035 With DISP_ARBITER_PRIO_EN, req=1111 -> owner stays 0 until req[0] drops; without the macro -> round-robin per REQ-031.

Source files
------------

// File: rtl/disp_pkg.sv
// Shared types and constants for the display arbiter.
// Optional feature macro: DISP_ARBITER_PRIO_EN (requester 0 has absolute
// priority and keeps the display while it requests).
package disp_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  localparam int unsigned N_REQ   = 4;
  localparam int unsigned DIGIT_W = 4;
  localparam int unsigned DISP_W  = 16;

`ifdef DISP_ARBITER_PRIO_EN
  localparam bit PRIO_EN = 1'b1;
`else
  localparam bit PRIO_EN = 1'b0;
`endif

  // One-hot encode a requester index.
  function automatic logic [N_REQ-1:0] onehot(input logic [1:0] idx);
    logic [N_REQ-1:0] v;
    v = 4'b0001 << idx;
    return v;
  endfunction

endpackage

// File: rtl/disp_arbiter_rr_pick.sv
// Combinational round-robin selector: first requester after 'last'
// (modulo 4). With DISP_ARBITER_PRIO_EN, requester 0 always wins.
module rr_pick
  import disp_pkg::*;
(
  input  logic [3:0] req,
  input  logic [1:0] last,
  output logic [1:0] pick,
  output logic       any
);

  logic       found_s;
  logic [1:0] idx_s;

  // Scan last+1 .. last+4; the first set request is the pick.
  always_comb begin
    pick    = 2'd0;
    any     = |req;
    found_s = 1'b0;
    idx_s   = 2'd0;
    for (int k = 1; k <= 4; k++) begin
      idx_s = last + 2'(k);
      if (!found_s && req[idx_s]) begin
        pick    = idx_s;
        found_s = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
    if (PRIO_EN && req[0]) begin
      pick = 2'd0;
    end else begin
      pick = pick;
    end
  end

endmodule

// File: rtl/disp_arbiter.sv
// Display arbiter: four requesters share one 4-digit hex display.
// A grant lasts at least DWELL cycles; after that it passes round-robin
// to another pending requester, is held if nobody else wants the display,
// or is released to IDLE when the owner has gone away.
// Optional feature macro: DISP_ARBITER_PRIO_EN (requester 0 preempts after
// the minimum dwell and keeps the grant while req[0] is high).
module disp_arbiter
  import disp_pkg::*;
#(
  parameter int unsigned DWELL = 100000000
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [3:0]  req,
  input  logic [63:0] x_in,
  input  logic [15:0] neg_in,
  output logic [3:0]  gnt,
  output logic [1:0]  owner,
  output logic        valid,
  output logic [15:0] x,
  output logic [3:0]  neg
);

  localparam logic [31:0] CNT_MAX = 32'(DWELL - 32'd1);

  state_e      state_q, state_d;
  logic [31:0] cnt_q,   cnt_d;
  logic [1:0]  last_q,  last_d;
  logic [1:0]  owner_q, owner_d;
  logic [3:0]  gnt_q,   gnt_d;
  logic        valid_q, valid_d;
  logic [15:0] x_q,     x_d;
  logic [3:0]  neg_q,   neg_d;

  logic [1:0]  pick_s;
  logic        any_s;
  logic [3:0]  others_s;
  logic        hold_prio_s;
  logic [15:0] x_sel_s;
  logic [3:0]  neg_sel_s;

  rr_pick u_rr_pick (
    .req  (req),
    .last (last_q),
    .pick (pick_s),
    .any  (any_s)
  );

  // Current owner's display data; x follows the owner registered at this edge.
  always_comb begin
    x_sel_s     = x_in[{owner_q, 4'b0000} +: 16];
    neg_sel_s   = neg_in[{owner_q, 2'b00} +: 4];
    others_s    = req & ~gnt_q;
    hold_prio_s = PRIO_EN && (owner_q == 2'd0) && req[0];
  end

  // Next-state and output decode for the IDLE/GRANT machine.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    owner_d = owner_q;
    gnt_d   = gnt_q;
    valid_d = valid_q;
    x_d     = x_q;
    neg_d   = neg_q;
    case (state_q)
      IDLE: begin
        x_d     = 16'h0000;
        neg_d   = 4'h0;
        gnt_d   = 4'h0;
        valid_d = 1'b0;
        cnt_d   = 32'd0;
        if (any_s) begin
          state_d = GRANT;
          gnt_d   = onehot(pick_s);
          owner_d = pick_s;
          last_d  = pick_s;
          valid_d = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      GRANT: begin
        x_d   = x_sel_s;
        neg_d = neg_sel_s;
        if (cnt_q != CNT_MAX) begin
          // Minimum dwell: hold regardless of req[owner].
          cnt_d = cnt_q + 32'd1;
        end else if (hold_prio_s) begin
          cnt_d = cnt_q;
        end else if (|others_s) begin
          // Direct hand-over; last==owner so the pick is never the owner.
          gnt_d   = onehot(pick_s);
          owner_d = pick_s;
          last_d  = pick_s;
          cnt_d   = 32'd0;
        end else if (req[owner_q]) begin
          cnt_d = cnt_q;
        end else begin
          state_d = IDLE;
          gnt_d   = 4'h0;
          valid_d = 1'b0;
          x_d     = 16'h0000;
          neg_d   = 4'h0;
          cnt_d   = 32'd0;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = 4'h0;
        valid_d = 1'b0;
        x_d     = 16'h0000;
        neg_d   = 4'h0;
        cnt_d   = 32'd0;
      end
    endcase
  end

  // State and output registers; reset aborts any grant immediately.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      cnt_q   <= 32'd0;
      last_q  <= 2'd3;
      owner_q <= 2'd0;
      gnt_q   <= 4'h0;
      valid_q <= 1'b0;
      x_q     <= 16'h0000;
      neg_q   <= 4'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      owner_q <= owner_d;
      gnt_q   <= gnt_d;
      valid_q <= valid_d;
      x_q     <= x_d;
      neg_q   <= neg_d;
    end
  end

  assign gnt   = gnt_q;
  assign owner = owner_q;
  assign valid = valid_q;
  assign x     = x_q;
  assign neg   = neg_q;

endmodule
